dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between the processor core and a DMA
// engine. The core has fixed priority; a DMA request that keeps losing is
// forced through after MAX_WAIT consecutive denied cycles, so the DMA
// engine cannot starve.
//
// Each cycle at most one request is granted (combinational c_gnt/d_gnt).
// A granted access is registered onto the memory port at the end of the
// grant cycle. Read data is captured one cycle later into rsp_data, and the
// owner's rvalid is high in the cycle after that. Two small pipeline stages
// (issue, response) remember which requester owns each in-flight read, so
// back-to-back grants run at full throughput and responses come back in
// grant order.
//
// Parameters
//   MAX_WAIT     max consecutive cycles a pending DMA request is denied (1..15)
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata   core request, write flag, address, write data
//   c_gnt        core request accepted this cycle (combinational)
//   c_rvalid     core read data valid on rsp_data
//   d_req/d_we/d_addr/d_wdata   DMA request, write flag, address, write data
//   d_gnt        DMA request accepted this cycle (combinational)
//   d_rvalid     DMA read data valid on rsp_data
//   rsp_data     registered read response shared by both requesters
//   mem_wr_en    registered write enable to data memory
//   mem_addr     registered address to data memory
//   mem_wr_data  registered write data to data memory
//   mem_rd_data  combinational read data from data memory
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] rsp_data,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    // Owner of the read held in a pipeline stage. Writes never occupy a
    // stage because they produce no response.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_C = 2'd1,
        ST_BUSY_D = 2'd2
    } stage_state_t;

    logic [3:0]   wait_cnt;
    logic         win_we;
    logic [31:0]  win_addr;
    logic [31:0]  win_wdata;
    stage_state_t iss_state;
    stage_state_t iss_next;
    stage_state_t rsp_state;
    stage_state_t rsp_next;

    // DMA wins when the core is quiet or when it has waited long enough.
    // Both grants are forced low while reset is asserted so nothing can be
    // accepted during reset even though the registers ignore it anyway.
    always_comb begin
        d_gnt = 1'b0;
        c_gnt = 1'b0;
        if (rst_n) begin
            d_gnt = d_req && (!c_req || (wait_cnt == WAIT_LIMIT));
            c_gnt = c_req && !d_gnt;
        end
    end

    // Select the fields of whichever requester won this cycle.
    always_comb begin
        win_we    = c_we;
        win_addr  = c_addr;
        win_wdata = c_wdata;
        if (d_gnt) begin
            win_we    = d_we;
            win_addr  = d_addr;
            win_wdata = d_wdata;
        end
    end

    // Starvation counter: counts consecutive denied DMA cycles and clears as
    // soon as the request is granted or withdrawn. Saturation at the limit
    // keeps it pinned there until the forced grant happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (!d_req || d_gnt) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Issue stage: drive the memory port. Address and data hold between
    // grants; only the write enable falls back to zero, so an idle cycle
    // never repeats a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_en   <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wr_data <= 32'd0;
        end else if (c_gnt || d_gnt) begin
            mem_wr_en   <= win_we;
            mem_addr    <= win_addr;
            mem_wr_data <= win_wdata;
        end else begin
            mem_wr_en   <= 1'b0;
        end
    end

    // Owner-tracking state registers for both pipeline stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_state <= ST_IDLE;
            rsp_state <= ST_IDLE;
        end else begin
            iss_state <= iss_next;
            rsp_state <= rsp_next;
        end
    end

    // A granted read enters the issue stage tagged with its owner; the
    // response stage simply inherits the issue stage one cycle later.
    always_comb begin
        iss_next = ST_IDLE;
        if (d_gnt && !d_we) begin
            iss_next = ST_BUSY_D;
        end else if (c_gnt && !c_we) begin
            iss_next = ST_BUSY_C;
        end
        rsp_next = iss_state;
    end

    // Memory read data is valid while a read sits in the issue stage. Since
    // memory writes land at the end of the cycle the write sits there, a
    // read granted right after a write to the same address sees new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= 32'd0;
        end else if (iss_state != ST_IDLE) begin
            rsp_data <= mem_rd_data;
        end
    end

    always_comb begin
        c_rvalid = (rsp_state == ST_BUSY_C);
        d_rvalid = (rsp_state == ST_BUSY_D);
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. A table of per-cycle vectors covers
// core write/read-back, a lone DMA read, alternating back-to-back reads and
// a withdrawn DMA request. Hand-written sequences cover reset behaviour,
// sustained contention with the MAX_WAIT fairness rule, and reset arriving
// while a write is on the memory port.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [31:0] rsp_data;
    logic        mem_wr_en;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic        c_req;
        logic        c_we;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        c_gnt;
        logic        d_gnt;
        logic        c_rvalid;
        logic        d_rvalid;
        logic        wr_en;
        logic [31:0] addr;
        logic [31:0] rsp;
    } vec_t;

    localparam int NUM_VECS = 17;
    vec_t vecs[NUM_VECS];

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .c_req       (c_req),
        .c_we        (c_we),
        .c_addr      (c_addr),
        .c_wdata     (c_wdata),
        .c_gnt       (c_gnt),
        .c_rvalid    (c_rvalid),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_gnt       (d_gnt),
        .d_rvalid    (d_rvalid),
        .rsp_data    (rsp_data),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    // Data memory: synchronous write, combinational read, word addressed.
    // Contents are preloaded on the first clock edge.
    logic [31:0] mem [256];
    logic        loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            mem[8'h08] <= 32'hA5A5_0020;
            mem[8'h0C] <= 32'h0BAD_F00D;
            mem[8'h10] <= 32'h1234_5678;
            mem[8'h14] <= 32'h5050_5050;
            mem[8'h18] <= 32'h6666_6666;
            loaded     <= 1'b1;
        end else if (mem_wr_en) begin
            mem[mem_addr[9:2]] <= mem_wr_data;
        end
    end

    assign mem_rd_data = mem[mem_addr[9:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic c_rq, input logic c_w, input logic [31:0] c_a, input logic [31:0] c_d,
        input logic d_rq, input logic d_w, input logic [31:0] d_a, input logic [31:0] d_d,
        input logic cg, input logic dg, input logic crv, input logic drv,
        input logic wen, input logic [31:0] addr, input logic [31:0] rsp);
        vec_t v;
        v.c_req = c_rq; v.c_we = c_w; v.c_addr = c_a; v.c_wdata = c_d;
        v.d_req = d_rq; v.d_we = d_w; v.d_addr = d_a; v.d_wdata = d_d;
        v.c_gnt = cg; v.d_gnt = dg; v.c_rvalid = crv; v.d_rvalid = drv;
        v.wr_en = wen; v.addr = addr; v.rsp = rsp;
        return v;
    endfunction

    task automatic idle_inputs();
        c_req = 1'b0; c_we = 1'b0; c_addr = 32'd0; c_wdata = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    endtask

    task automatic check_output(input int idx, input vec_t v);
        check($sformatf("v%0d c_gnt", idx),    32'(c_gnt),     32'(v.c_gnt));
        check($sformatf("v%0d d_gnt", idx),    32'(d_gnt),     32'(v.d_gnt));
        check($sformatf("v%0d c_rvalid", idx), 32'(c_rvalid),  32'(v.c_rvalid));
        check($sformatf("v%0d d_rvalid", idx), 32'(d_rvalid),  32'(v.d_rvalid));
        check($sformatf("v%0d mem_wr_en", idx), 32'(mem_wr_en), 32'(v.wr_en));
        check($sformatf("v%0d mem_addr", idx), mem_addr,       v.addr);
        check($sformatf("v%0d rsp_data", idx), rsp_data,       v.rsp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One core read, checked two cycles after its grant.
    task automatic core_read_check(input string name, input logic [31:0] addr,
                                   input logic [31:0] exp);
        idle_inputs();
        c_req = 1'b1; c_addr = addr;
        @(negedge clk);
        check({name, " gnt"}, 32'(c_gnt), 32'd1);
        next_cycle();
        idle_inputs();
        next_cycle();
        @(negedge clk);
        check({name, " c_rvalid"}, 32'(c_rvalid), 32'd1);
        check({name, " rsp_data"}, rsp_data, exp);
        next_cycle();
    endtask

    initial begin
        bit d_win;
        bit prev_d_win;

        // Directed per-cycle vectors (inputs for the cycle, outputs expected
        // during that same cycle).
        //              c_req we addr         wdata          d_req we addr   wdata         cg dg crv drv wen addr   rsp
        vecs[0]  = mk(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 0, 32'h0,  32'h0);
        vecs[1]  = mk(1, 0, 32'h10, 32'h0,         0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 1, 32'h10, 32'h0);
        vecs[2]  = mk(0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 32'h10, 32'h0);
        vecs[3]  = mk(0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,        0, 0, 1, 0, 0, 32'h10, 32'hDEAD_BEEF);
        vecs[4]  = mk(0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 32'h10, 32'hDEAD_BEEF);
        vecs[5]  = mk(0, 0, 32'h0,  32'h0,         1, 0, 32'h40, 32'h0,        0, 1, 0, 0, 0, 32'h10, 32'hDEAD_BEEF);
        vecs[6]  = mk(0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 32'h40, 32'hDEAD_BEEF);
        vecs[7]  = mk(0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 32'h40, 32'h1234_5678);
        vecs[8]  = mk(1, 0, 32'h20, 32'h0,         0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 0, 32'h40, 32'h1234_5678);
        vecs[9]  = mk(0, 0, 32'h0,  32'h0,         1, 0, 32'h30, 32'h0,        0, 1, 0, 0, 0, 32'h20, 32'h1234_5678);
        vecs[10] = mk(1, 0, 32'h40, 32'h0,         0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 0, 32'h30, 32'hA5A5_0020);
        vecs[11] = mk(0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 32'h40, 32'h0BAD_F00D);
        vecs[12] = mk(0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,        0, 0, 1, 0, 0, 32'h40, 32'h1234_5678);
        vecs[13] = mk(0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 32'h40, 32'h1234_5678);
        vecs[14] = mk(1, 0, 32'h20, 32'h0,         1, 1, 32'h50, 32'h1111_1111, 1, 0, 0, 0, 0, 32'h40, 32'h1234_5678);
        vecs[15] = mk(0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 32'h20, 32'h1234_5678);
        vecs[16] = mk(0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,        0, 0, 1, 0, 0, 32'h20, 32'hA5A5_0020);

        // Reset state, with both requesters asking to be served.
        idle_inputs();
        c_req = 1'b1; d_req = 1'b1;
        #2;
        check("reset c_gnt",       32'(c_gnt),     32'd0);
        check("reset d_gnt",       32'(d_gnt),     32'd0);
        check("reset mem_wr_en",   32'(mem_wr_en), 32'd0);
        check("reset mem_addr",    mem_addr,       32'd0);
        check("reset mem_wr_data", mem_wr_data,    32'd0);
        check("reset rsp_data",    rsp_data,       32'd0);
        check("reset c_rvalid",    32'(c_rvalid),  32'd0);
        check("reset d_rvalid",    32'(d_rvalid),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset held c_gnt", 32'(c_gnt), 32'd0);
        check("reset held d_gnt", 32'(d_gnt), 32'd0);
        check("reset held mem_wr_en", 32'(mem_wr_en), 32'd0);
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;

        for (int i = 0; i < NUM_VECS; i++) begin
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_output(i, vecs[i]);
            next_cycle();
        end

        // Sustained contention: DMA is forced through every fifth cycle and
        // responses follow their grants two cycles later at full rate.
        prev_d_win = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle_inputs();
            c_req = 1'b1; c_addr = 32'h20;
            d_req = 1'b1; d_addr = 32'h30;
            d_win = ((i % (MAX_WAIT + 1)) == MAX_WAIT);
            @(negedge clk);
            check($sformatf("starve%0d d_gnt", i), 32'(d_gnt), 32'(d_win));
            check($sformatf("starve%0d c_gnt", i), 32'(c_gnt), 32'(!d_win));
            if (i >= 2) begin
                prev_d_win = (((i - 2) % (MAX_WAIT + 1)) == MAX_WAIT);
                check($sformatf("starve%0d c_rvalid", i), 32'(c_rvalid), 32'(!prev_d_win));
                check($sformatf("starve%0d d_rvalid", i), 32'(d_rvalid), 32'(prev_d_win));
                check($sformatf("starve%0d rsp_data", i), rsp_data,
                      prev_d_win ? 32'h0BAD_F00D : 32'hA5A5_0020);
            end
            next_cycle();
        end
        idle_inputs();
        repeat (3) next_cycle();

        // The withdrawn DMA write from the vector table must not have landed.
        core_read_check("withdrawn", 32'h50, 32'h5050_5050);

        // Reset while a core write is on the memory port.
        idle_inputs();
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h60; c_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("rstwr c_gnt", 32'(c_gnt), 32'd1);
        next_cycle();
        check("rstwr mem_wr_en before reset", 32'(mem_wr_en), 32'd1);
        check("rstwr mem_addr before reset",  mem_addr,       32'h60);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rstwr mem_wr_en async", 32'(mem_wr_en), 32'd0);
        check("rstwr mem_addr async",  mem_addr,       32'd0);
        check("rstwr mem_wr_data async", mem_wr_data,  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rstwr post%0d c_rvalid", i), 32'(c_rvalid), 32'd0);
            check($sformatf("rstwr post%0d d_rvalid", i), 32'(d_rvalid), 32'd0);
            check($sformatf("rstwr post%0d mem_wr_en", i), 32'(mem_wr_en), 32'd0);
            next_cycle();
        end
        check("rstwr memory untouched", mem[8'h18], 32'h6666_6666);
        core_read_check("rstwr readback", 32'h60, 32'h6666_6666);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
